// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream (length, LE words, XOR checksum),
// writes one word per instruction and holds the CPU in reset until a verified image is present.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reload,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned IDX_W    = ADDR_W + 1;
    localparam int unsigned CAPACITY = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    logic [7:0]         len_lo;
    logic [15:0]        count;
    logic [IDX_W-1:0]   index;
    logic [7:0]         xsum;
    logic [23:0]        word;
    logic [1:0]         byte_cnt;
    logic               accept;
    logic [15:0]        len;

    // The only combinational output: ready depends on state and the reload/reset inputs.
    assign byte_ready = !reset && !reload &&
                        (state == S_LEN_LO || state == S_LEN_HI ||
                         state == S_DATA   || state == S_CSUM);
    assign accept     = byte_valid && byte_ready;
    assign len        = {byte_data, len_lo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_LEN_LO;
            len_lo     <= 8'h00;
            count      <= 16'h0000;
            index      <= '0;
            xsum       <= 8'h00;
            word       <= 24'h000000;
            byte_cnt   <= 2'd0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'h0000_0000;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (reload) begin
                state    <= S_LEN_LO;
                index    <= '0;
                xsum     <= 8'h00;
                byte_cnt <= 2'd0;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
            end else begin
                case (state)
                    S_LEN_LO: if (accept) begin
                        len_lo <= byte_data;
                        xsum   <= xsum ^ byte_data;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: if (accept) begin
                        count    <= len;
                        xsum     <= xsum ^ byte_data;
                        byte_cnt <= 2'd0;
                        if (32'(len) > CAPACITY) begin
                            error <= 1'b1;
                            state <= S_ERROR;
                        end else if (len == 16'h0000) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    // Write strobe is registered on the 4th byte so it is high during S_WRITE.
                    S_DATA: if (accept) begin
                        xsum     <= xsum ^ byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        word     <= {byte_data, word[23:8]};
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= BASE_ADDR + (32'(index) << 2);
                            imem_wdata <= {byte_data, word};
                            state      <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        index <= index + IDX_W'(1);
                        if (16'(index) + 16'd1 == count) state <= S_CSUM;
                        else                             state <= S_DATA;
                    end
                    S_CSUM: if (accept) begin
                        if (byte_data == xsum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            error <= 1'b1;
                            state <= S_ERROR;
                        end
                    end
                    S_DONE:  state <= S_DONE;
                    S_ERROR: state <= S_ERROR;
                    default: state <= S_LEN_LO;
                endcase
            end
        end
    end

endmodule
